// File: rtl/rdm_combine_writer.sv
// rdm_combine_writer: receives RDM words, soft-combines them with the stored HARQ
// buffer using saturating read-modify-write, and checks the word count against Ncb.
`default_nettype none
module rdm_combine_writer #(
  parameter int DATA_WIDTH      = 96,
  parameter int LLR_WIDTH       = 6,
  parameter int LANES           = 16,
  parameter int ADDR_WIDTH      = 12,
  parameter int USER_WORDS_LOG2 = 8
) (
  input  logic                  i_core_clk,
  input  logic                  i_rx_rstn,
  input  logic                  i_combine_start,
  input  logic [3:0]            i_user_index,
  input  logic [15:0]           i_ncb_size,
  input  logic                  i_first_tx,
  output logic                  o_combine_process_request,
  output logic                  o_rdm_data_request,
  input  logic                  i_rdm_data_valid,
  input  logic                  i_rdm_data_comp,
  input  logic [DATA_WIDTH-1:0] i_rdm_data_content,
  output logic                  o_harq_rd_en,
  output logic [ADDR_WIDTH-1:0] o_harq_rd_addr,
  input  logic [DATA_WIDTH-1:0] i_harq_rd_data,
  output logic                  o_harq_wr_en,
  output logic [ADDR_WIDTH-1:0] o_harq_wr_addr,
  output logic [DATA_WIDTH-1:0] o_harq_wr_data,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_short_err,
  output logic                  o_long_err
);
  localparam int LANE_BITS = $clog2(LANES);
  localparam int CNT_W     = 16 - LANE_BITS + 1;

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_RECV, S_DRAIN, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [3:0]           user_q, user_d;
  logic                 first_q, first_d;
  logic [CNT_W-1:0]     exp_q, exp_d;
  logic [LANE_BITS-1:0] rem_q, rem_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 drain_q, drain_d;
  logic                 short_q, short_d;
  logic                 long_q, long_d;

  logic                  s1_vld_q, s2_vld_q;
  logic [ADDR_WIDTH-1:0] s1_addr_q, s2_addr_q;
  logic [DATA_WIDTH-1:0] s1_data_q, s2_data_q;
  logic [LANES-1:0]      s1_mask_q;

  logic [CNT_W-1:0]      w_start_exp;
  logic                  w_in_recv, w_accept, w_drop, w_last;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [LANES-1:0]      w_mask;
  logic [DATA_WIDTH-1:0] w_merged;

  function automatic logic [LLR_WIDTH-1:0] sat_add(input logic [LLR_WIDTH-1:0] a,
                                                   input logic [LLR_WIDTH-1:0] b);
    logic [LLR_WIDTH:0] s;
    s = {a[LLR_WIDTH-1], a} + {b[LLR_WIDTH-1], b};
    if (s[LLR_WIDTH] != s[LLR_WIDTH-1])
      sat_add = s[LLR_WIDTH] ? {1'b1, {(LLR_WIDTH-1){1'b0}}} : {1'b0, {(LLR_WIDTH-1){1'b1}}};
    else
      sat_add = s[LLR_WIDTH-1:0];
  endfunction

  assign w_start_exp = {1'b0, i_ncb_size[15:LANE_BITS]} + CNT_W'(|i_ncb_size[LANE_BITS-1:0]);
  assign w_in_recv   = (state_q == S_RECV);
  assign w_accept    = w_in_recv && i_rdm_data_valid && (cnt_q < exp_q);
  assign w_drop      = w_in_recv && i_rdm_data_valid && !(cnt_q < exp_q);
  assign w_addr      = ADDR_WIDTH'({user_q, cnt_q[USER_WORDS_LOG2-1:0]});
  assign w_last      = (cnt_q == exp_q - CNT_W'(1)) && (rem_q != '0);

  always_comb begin
    w_mask = '1;
    for (int i = 0; i < LANES; i++)
      if (w_last && !(LANE_BITS'(i) < rem_q)) w_mask[i] = 1'b0;
  end

  // Old data is forced to zero on a first transmission so masked-off lanes stay clean.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [LLR_WIDTH-1:0] w_old;
    assign w_old = first_q ? '0 : i_harq_rd_data[l*LLR_WIDTH +: LLR_WIDTH];
    assign w_merged[l*LLR_WIDTH +: LLR_WIDTH] =
      s1_mask_q[l] ? sat_add(w_old, s1_data_q[l*LLR_WIDTH +: LLR_WIDTH]) : w_old;
  end

  always_comb begin
    state_d = state_q;
    user_d  = user_q;
    first_d = first_q;
    exp_d   = exp_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    drain_d = drain_q;
    short_d = short_q;
    long_d  = long_q;
    case (state_q)
      S_IDLE: begin
        if (i_combine_start) begin
          user_d  = i_user_index;
          first_d = i_first_tx;
          exp_d   = w_start_exp;
          rem_d   = i_ncb_size[LANE_BITS-1:0];
          cnt_d   = '0;
          short_d = 1'b0;
          long_d  = 1'b0;
          if (w_start_exp == '0) begin
            state_d = S_DONE;
          end else if (w_start_exp > (CNT_W'(1) << USER_WORDS_LOG2)) begin
            long_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: state_d = S_RECV;
      S_RECV: begin
        if (w_accept) cnt_d = cnt_q + CNT_W'(1);
        if (w_drop) long_d = 1'b1;
        if (i_rdm_data_comp) begin
          if ((cnt_q + CNT_W'(w_accept)) < exp_q) short_d = 1'b1;
          drain_d = 1'b0;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (drain_q) state_d = S_DONE;
        else drain_d = 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
    if (!i_rx_rstn) begin
      state_q <= S_IDLE;
      user_q  <= '0;
      first_q <= 1'b0;
      exp_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      drain_q <= 1'b0;
      short_q <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      user_q  <= user_d;
      first_q <= first_d;
      exp_q   <= exp_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      drain_q <= drain_d;
      short_q <= short_d;
      long_q  <= long_d;
    end
  end

  always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
    if (!i_rx_rstn) begin
      s1_vld_q  <= 1'b0;
      s1_addr_q <= '0;
      s1_data_q <= '0;
      s1_mask_q <= '0;
      s2_vld_q  <= 1'b0;
      s2_addr_q <= '0;
      s2_data_q <= '0;
    end else begin
      s1_vld_q <= w_accept;
      if (w_accept) begin
        s1_addr_q <= w_addr;
        s1_data_q <= i_rdm_data_content;
        s1_mask_q <= w_mask;
      end
      s2_vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        s2_addr_q <= s1_addr_q;
        s2_data_q <= w_merged;
      end
    end
  end

  assign o_combine_process_request = (state_q == S_REQ);
  assign o_rdm_data_request        = w_in_recv;
  assign o_harq_rd_en              = w_accept && !first_q;
  assign o_harq_rd_addr            = w_addr;
  assign o_harq_wr_en              = s2_vld_q;
  assign o_harq_wr_addr            = s2_addr_q;
  assign o_harq_wr_data            = s2_data_q;
  assign o_busy                    = (state_q != S_IDLE);
  assign o_done                    = (state_q == S_DONE);
  assign o_short_err               = short_q;
  assign o_long_err                = long_q;
endmodule
`default_nettype wire
